// File: rtl/spi_boot_pkg.sv
// spi_boot_pkg: shared FSM state encoding and checksum width for the SPI boot loader.
// Rev 1.0
`default_nettype none

package spi_boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  localparam int CSUM_W = 8;

endpackage

`default_nettype wire

// File: rtl/spi_boot_loader_if.sv
// spi_boot_loader_if: SRAM arbiter write port (req/ack handshake).
// Rev 1.0
`default_nettype none

interface spi_boot_loader_if #(
  parameter int MEM_AW = 18
);

  logic              mem_req;
  logic              mem_ack;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_data,
    output mem_ack
  );

endinterface

`default_nettype wire

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronises the SPI pins, detects sclk rises and assembles MSB-first bytes.
// Rev 1.0
`default_nettype none

module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       ss_n,
  input  wire logic       sclk,
  input  wire logic       mosi,
  output logic [7:0]      data_byte,
  output logic            byte_valid,
  output logic            ss_fall,
  output logic            ss_rise,
  output logic            ss_level
);

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ss_prev;
  logic                   sclk_prev;
  logic [6:0]             shift;
  logic [2:0]             bit_cnt;
  logic                   ss_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise;

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s && !sclk_prev;
  assign ss_fall   = ss_prev && !ss_s;
  assign ss_rise   = !ss_prev && ss_s;
  assign ss_level  = ss_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Select resets to its idle (high) level so leaving reset never fakes a session start.
      ss_sync    <= '1;
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      ss_prev    <= 1'b1;
      sclk_prev  <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
    end else begin
      ss_sync    <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_prev    <= ss_s;
      sclk_prev  <= sclk_s;
      byte_valid <= 1'b0;
      if (ss_s || ss_fall) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_byte  <= {shift, mosi_s};
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_boot_loader.sv
// spi_boot_loader: SPI slave that parses region headers and streams image bytes into SRAM.
// Rev 1.0
`default_nettype none

module spi_boot_loader
  import spi_boot_pkg::*;
#(
  parameter int ADDR_BYTES  = 3,
  parameter int MEM_AW      = 18,
  parameter int CHECKSUM_EN = 1,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic          CLK32M_I,
  input  wire logic          RESET_I,
  input  wire logic          arm_ss,
  input  wire logic          arm_sclk,
  input  wire logic          arm_mosi,
  spi_boot_loader_if.master  mem,
  output logic               busy,
  output logic               done,
  output logic               err_csum,
  output logic               err_order,
  output logic               err_overrun,
  output logic [7:0]         region_count
);

  localparam int ADDR_W = ADDR_BYTES * 8;
  localparam int HDR_W  = 2 * ADDR_W;
  localparam int HDR_N  = 2 * ADDR_BYTES;
  localparam int IDX_W  = $clog2(HDR_N);
  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(HDR_N - 1);

  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              ss_fall;
  logic              ss_rise;
  logic              ss_level;

  state_t            state;
  logic [IDX_W-1:0]  hdr_idx;
  logic [HDR_W-9:0]  hdr_q;
  logic [HDR_W-1:0]  hdr_next;
  logic [MEM_AW-1:0] start_t;
  logic [MEM_AW-1:0] end_t;
  logic [MEM_AW-1:0] ptr;
  logic [MEM_AW-1:0] end_r;
  logic [CSUM_W-1:0] csum;
  logic [CSUM_W-1:0] csum_next;
  logic              mem_req_r;
  logic [MEM_AW-1:0] mem_addr_r;
  logic [7:0]        mem_data_r;
  logic              wr_stalled;
  logic              done_armed;
  logic [7:0]        rc_inc;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk        (CLK32M_I),
    .rst        (RESET_I),
    .ss_n       (arm_ss),
    .sclk       (arm_sclk),
    .mosi       (arm_mosi),
    .data_byte  (rx_byte),
    .byte_valid (byte_valid),
    .ss_fall    (ss_fall),
    .ss_rise    (ss_rise),
    .ss_level   (ss_level)
  );

  // Header arrives little-endian; the incoming byte lands in the top of the window.
  always_comb begin
    hdr_next   = {rx_byte, hdr_q};
    start_t    = MEM_AW'(hdr_next[ADDR_W-1:0]);
    end_t      = MEM_AW'(hdr_next[HDR_W-1:ADDR_W]);
    csum_next  = csum + rx_byte;
    wr_stalled = mem_req_r && !mem.mem_ack;
    rc_inc     = (region_count == 8'hFF) ? region_count : region_count + 8'd1;
  end

  assign mem.mem_req  = mem_req_r;
  assign mem.mem_addr = mem_addr_r;
  assign mem.mem_data = mem_data_r;
  assign busy         = !ss_level || mem_req_r;

  always_ff @(posedge CLK32M_I) begin
    if (RESET_I) begin
      state        <= IDLE;
      hdr_idx      <= '0;
      hdr_q        <= '0;
      ptr          <= '0;
      end_r        <= '0;
      csum         <= '0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
      mem_data_r   <= '0;
      done_armed   <= 1'b0;
      done         <= 1'b0;
      err_csum     <= 1'b0;
      err_order    <= 1'b0;
      err_overrun  <= 1'b0;
      region_count <= '0;
    end else begin
      done <= 1'b0;
      if (mem_req_r && mem.mem_ack) begin
        mem_req_r <= 1'b0;
      end
      if (byte_valid && wr_stalled) begin
        err_overrun <= 1'b1;
      end

      if (ss_fall) begin
        err_csum     <= 1'b0;
        err_order    <= 1'b0;
        err_overrun  <= 1'b0;
        region_count <= '0;
        csum         <= '0;
        hdr_idx      <= '0;
        done_armed   <= 1'b0;
        state        <= HDR;
      end else if (ss_rise) begin
        done_armed <= 1'b1;
        state      <= IDLE;
      end else if (byte_valid) begin
        case (state)
          HDR: begin
            csum  <= csum_next;
            hdr_q <= hdr_next[HDR_W-1:8];
            if (hdr_idx == HDR_LAST) begin
              hdr_idx <= '0;
              if (start_t > end_t) begin
                err_order <= 1'b1;
                state     <= IGNORE;
              end else begin
                ptr   <= start_t;
                end_r <= end_t;
                state <= DATA;
              end
            end else begin
              hdr_idx <= hdr_idx + 1'b1;
            end
          end
          DATA: begin
            csum <= csum_next;
            // A byte arriving behind a stalled write is dropped; the region still advances.
            if (!wr_stalled) begin
              mem_req_r  <= 1'b1;
              mem_addr_r <= ptr;
              mem_data_r <= rx_byte;
            end
            if (ptr == end_r) begin
              if (CHECKSUM_EN != 0) begin
                state <= CSUM;
              end else begin
                region_count <= rc_inc;
                csum         <= '0;
                state        <= HDR;
              end
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          CSUM: begin
            if (csum_next != '0) begin
              err_csum <= 1'b1;
            end else begin
              region_count <= rc_inc;
            end
            csum  <= '0;
            state <= HDR;
          end
          default: begin
          end
        endcase
      end

      if (done_armed && ss_level && !mem_req_r) begin
        done_armed <= 1'b0;
        done       <= (region_count != 8'd0) && !err_csum && !err_order && !err_overrun;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader: two loaders (checksum off/on) driven over a shared SPI bus with a write scoreboard.
// Rev 1.0
`default_nettype none

module tb_spi_boot_loader;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic ss0  = 1'b1;
  logic ss1  = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;

  logic       busy0, done0, ec0, eo0, ev0;
  logic [7:0] rc0;
  logic       busy1, done1, ec1, eo1, ev1;
  logic [7:0] rc1;

  spi_boot_loader_if #(.MEM_AW(18)) if0 ();
  spi_boot_loader_if #(.MEM_AW(18)) if1 ();

  spi_boot_loader #(
    .ADDR_BYTES(3), .MEM_AW(18), .CHECKSUM_EN(0), .SYNC_STAGES(2)
  ) dut0 (
    .CLK32M_I(clk), .RESET_I(rst), .arm_ss(ss0), .arm_sclk(sclk), .arm_mosi(mosi),
    .mem(if0.master), .busy(busy0), .done(done0), .err_csum(ec0), .err_order(eo0),
    .err_overrun(ev0), .region_count(rc0)
  );

  spi_boot_loader #(
    .ADDR_BYTES(3), .MEM_AW(18), .CHECKSUM_EN(1), .SYNC_STAGES(2)
  ) dut1 (
    .CLK32M_I(clk), .RESET_I(rst), .arm_ss(ss1), .arm_sclk(sclk), .arm_mosi(mosi),
    .mem(if1.master), .busy(busy1), .done(done1), .err_csum(ec1), .err_order(eo1),
    .err_overrun(ev1), .region_count(rc1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    string       tag;
    logic [23:0] st;
    logic [23:0] en;
    int          cmode;   // 0 none, 1 correct checksum, 2 corrupted checksum
    int          extra;   // bytes sent after a rejected header
    logic        e_cs;
    logic        e_or;
    logic [7:0]  e_rc;
    int          e_done;
  } vec_t;

  wr_t         exp0[$];
  wr_t         exp1[$];
  wr_t         e0, e1;
  logic [7:0]  tx_q[$];
  logic [7:0]  data_q[$];
  vec_t        vecs[7];
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt0 = 0;
  int          done_cnt1 = 0;
  int          dstart;
  int          k;
  logic [17:0] a0;
  logic [7:0]  d0;
  bit          stable;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (if0.mem_req && if0.mem_ack) begin
      if (exp0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr0_unexpected: got write %0h=%0h, required none", if0.mem_addr, if0.mem_data);
      end else begin
        e0 = exp0.pop_front();
        chk("wr0_addr", 32'(if0.mem_addr), 32'(e0.addr));
        chk("wr0_data", 32'(if0.mem_data), 32'(e0.data));
      end
    end
    if (if1.mem_req && if1.mem_ack) begin
      if (exp1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr1_unexpected: got write %0h=%0h, required none", if1.mem_addr, if1.mem_data);
      end else begin
        e1 = exp1.pop_front();
        chk("wr1_addr", 32'(if1.mem_addr), 32'(e1.addr));
        chk("wr1_data", 32'(if1.mem_data), 32'(e1.data));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      wait_cyc(4);
      sclk = 1'b1;
      wait_cyc(4);
      sclk = 1'b0;
    end
  endtask

  task automatic set_ss(input int sel, input logic v);
    if (sel == 0) ss0 = v;
    else          ss1 = v;
  endtask

  task automatic run_session(input int sel);
    set_ss(sel, 1'b0);
    wait_cyc(8);
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    wait_cyc(8);
    set_ss(sel, 1'b1);
    wait_cyc(30);
  endtask

  // Queue one region's bytes and the SRAM writes it should produce.
  task automatic add_region(input int sel, input logic [23:0] st, input logic [23:0] en,
                            input int cmode, input int extra);
    logic [7:0]  s = 8'h00;
    logic [7:0]  b;
    logic [17:0] st_t = st[17:0];
    logic [17:0] en_t = en[17:0];
    wr_t         w;
    for (int i = 0; i < 3; i++) begin
      b = st[8*i +: 8];
      tx_q.push_back(b);
      s = s + b;
    end
    for (int i = 0; i < 3; i++) begin
      b = en[8*i +: 8];
      tx_q.push_back(b);
      s = s + b;
    end
    if (st_t > en_t) begin
      for (int i = 0; i < extra; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    end else begin
      for (int a = int'(st_t); a <= int'(en_t); a++) begin
        b = (data_q.size() > 0) ? data_q.pop_front() : 8'($urandom_range(0, 255));
        tx_q.push_back(b);
        s = s + b;
        w.addr = 18'(a);
        w.data = b;
        if (sel == 0) exp0.push_back(w);
        else          exp1.push_back(w);
      end
      b = 8'h00 - s;
      if (cmode == 1) tx_q.push_back(b);
      if (cmode == 2) tx_q.push_back(b ^ 8'h01);
    end
  endtask

  task automatic check_status(input int sel, input string tag, input int d_before,
                              input logic e_cs, input logic e_or, input logic e_ov,
                              input logic [7:0] e_rc, input int e_done);
    chk({tag, " err_csum"},    32'(sel ? ec1 : ec0), 32'(e_cs));
    chk({tag, " err_order"},   32'(sel ? eo1 : eo0), 32'(e_or));
    chk({tag, " err_overrun"}, 32'(sel ? ev1 : ev0), 32'(e_ov));
    chk({tag, " region_count"}, 32'(sel ? rc1 : rc0), 32'(e_rc));
    chk({tag, " done_pulses"}, 32'((sel ? done_cnt1 : done_cnt0) - d_before), 32'(e_done));
    chk({tag, " writes_left"}, 32'(sel ? exp1.size() : exp0.size()), 32'd0);
    chk({tag, " busy_idle"},   32'(sel ? busy1 : busy0), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"multi",    24'h004000, 24'h004002, 1, 0, 1'b0, 1'b0, 8'd1, 1};
    vecs[1] = '{"single",   24'h00C000, 24'h00C000, 1, 0, 1'b0, 1'b0, 8'd1, 1};
    vecs[2] = '{"top_end",  24'h03FFFE, 24'h03FFFF, 1, 0, 1'b0, 1'b0, 8'd1, 1};
    vecs[3] = '{"bad_csum", 24'h000020, 24'h000021, 2, 0, 1'b1, 1'b0, 8'd0, 0};
    vecs[4] = '{"order",    24'h000010, 24'h00000F, 0, 3, 1'b0, 1'b1, 8'd0, 0};
    vecs[5] = '{"trunc",    24'h1C0005, 24'h1C0006, 1, 0, 1'b0, 1'b0, 8'd1, 1};
    vecs[6] = '{"clean",    24'h000050, 24'h000052, 1, 0, 1'b0, 1'b0, 8'd1, 1};

    if0.mem_ack = 1'b1;
    if1.mem_ack = 1'b1;
    wait_cyc(4);
    chk("rst mem_req",      32'(if1.mem_req), 32'd0);
    chk("rst busy",         32'(busy1), 32'd0);
    chk("rst done",         32'(done1), 32'd0);
    chk("rst region_count", 32'(rc1), 32'd0);
    chk("rst errors",       32'({ec1, eo1, ev1}), 32'd0);
    chk("rst busy0",        32'(busy0), 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    // Checksum-free loader: one region.
    dstart = done_cnt0;
    data_q = '{8'hA2, 8'h80, 8'h11, 8'h22};
    add_region(0, 24'h00C000, 24'h00C003, 0, 0);
    run_session(0);
    check_status(0, "nocsum", dstart, 1'b0, 1'b0, 1'b0, 8'd1, 1);

    // Two checksummed regions in a single session.
    dstart = done_cnt1;
    data_q = '{8'h55, 8'hAA};
    add_region(1, 24'h008000, 24'h008001, 1, 0);
    data_q = '{8'h01, 8'h02};
    add_region(1, 24'h01FFFE, 24'h01FFFF, 1, 0);
    run_session(1);
    check_status(1, "two_reg", dstart, 1'b0, 1'b0, 1'b0, 8'd2, 1);

    for (int v = 0; v < 7; v++) begin
      dstart = done_cnt1;
      add_region(1, vecs[v].st, vecs[v].en, vecs[v].cmode, vecs[v].extra);
      run_session(1);
      check_status(1, vecs[v].tag, dstart, vecs[v].e_cs, vecs[v].e_or, 1'b0,
                   vecs[v].e_rc, vecs[v].e_done);
    end

    // Stalled arbiter: the first write must hold while later bytes overrun and are dropped.
    if1.mem_ack = 1'b0;
    dstart = done_cnt1;
    data_q = '{8'h3C, 8'h11, 8'h22, 8'h33};
    add_region(1, 24'h000100, 24'h000103, 1, 0);
    repeat (3) void'(exp1.pop_back());
    data_q = '{8'h5A};
    add_region(1, 24'h000200, 24'h000200, 1, 0);
    fork
      run_session(1);
      begin
        k = 0;
        while (!if1.mem_req && k < 3000) begin
          wait_cyc(1);
          k++;
        end
        chk("ovr req_seen", 32'(if1.mem_req), 32'd1);
        a0 = if1.mem_addr;
        d0 = if1.mem_data;
        chk("ovr first_addr", 32'(a0), 32'h100);
        chk("ovr first_data", 32'(d0), 32'h3C);
        stable = 1'b1;
        for (int c = 0; c < 200; c++) begin
          wait_cyc(1);
          if (if1.mem_req !== 1'b1 || if1.mem_addr !== a0 || if1.mem_data !== d0) stable = 1'b0;
        end
        chk("ovr hold_stable", 32'(stable), 32'd1);
        if1.mem_ack = 1'b1;
      end
    join
    check_status(1, "overrun", dstart, 1'b0, 1'b0, 1'b1, 8'd2, 0);

    // Reset during DATA with a write outstanding.
    if1.mem_ack = 1'b0;
    dstart = done_cnt1;
    tx_q = '{8'h00, 8'h03, 8'h00, 8'h07, 8'h03, 8'h00, 8'h77};
    ss1 = 1'b0;
    wait_cyc(8);
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    k = 0;
    while (!if1.mem_req && k < 500) begin
      wait_cyc(1);
      k++;
    end
    chk("rstmid req_before", 32'(if1.mem_req), 32'd1);
    rst = 1'b1;
    ss1 = 1'b1;
    wait_cyc(1);
    chk("rstmid mem_req", 32'(if1.mem_req), 32'd0);
    chk("rstmid busy",    32'(busy1), 32'd0);
    wait_cyc(3);
    rst = 1'b0;
    if1.mem_ack = 1'b1;
    wait_cyc(10);
    chk("rstmid no_done", 32'(done_cnt1 - dstart), 32'd0);
    dstart = done_cnt1;
    add_region(1, 24'h000310, 24'h000311, 1, 0);
    run_session(1);
    check_status(1, "after_rst", dstart, 1'b0, 1'b0, 1'b0, 8'd1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
